// File: rtl/ysyx_22050550_axi_arb.sv
// Two-master (I-cache m0, D-cache m1) to one-slave AXI4 arbiter; one burst outstanding at a time.
// Optional features: ARB_RR_EN (round-robin between masters), ARB_CHECK_EN (beat-count protocol check).
module ysyx_22050550_axi_arb #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  // m0: I-cache read
  input  logic                  io_m0_ar_valid,
  input  logic [ADDR_W-1:0]     io_m0_ar_addr,
  input  logic [7:0]            io_m0_ar_len,
  input  logic [2:0]            io_m0_ar_size,
  input  logic [1:0]            io_m0_ar_burst,
  output logic                  io_m0_ar_ready,
  output logic                  io_m0_r_valid,
  output logic                  io_m0_r_last,
  output logic [DATA_W-1:0]     io_m0_r_rdata,
  input  logic                  io_m0_r_ready,
  // m1: D-cache read
  input  logic                  io_m1_ar_valid,
  input  logic [ADDR_W-1:0]     io_m1_ar_addr,
  input  logic [7:0]            io_m1_ar_len,
  input  logic [2:0]            io_m1_ar_size,
  input  logic [1:0]            io_m1_ar_burst,
  output logic                  io_m1_ar_ready,
  output logic                  io_m1_r_valid,
  output logic                  io_m1_r_last,
  output logic [DATA_W-1:0]     io_m1_r_rdata,
  input  logic                  io_m1_r_ready,
  // m1: D-cache write-back
  input  logic                  io_m1_aw_valid,
  input  logic [ADDR_W-1:0]     io_m1_aw_addr,
  input  logic [7:0]            io_m1_aw_len,
  input  logic [2:0]            io_m1_aw_size,
  input  logic [1:0]            io_m1_aw_burst,
  output logic                  io_m1_aw_ready,
  input  logic                  io_m1_w_valid,
  input  logic [DATA_W-1:0]     io_m1_w_data,
  input  logic [DATA_W/8-1:0]   io_m1_w_strb,
  input  logic                  io_m1_w_last,
  output logic                  io_m1_w_ready,
  input  logic                  io_m1_b_ready,
  output logic                  io_m1_b_valid,
  // slave side
  output logic                  io_s_ar_valid,
  output logic [ADDR_W-1:0]     io_s_ar_addr,
  output logic [7:0]            io_s_ar_len,
  output logic [2:0]            io_s_ar_size,
  output logic [1:0]            io_s_ar_burst,
  input  logic                  io_s_ar_ready,
  input  logic                  io_s_r_valid,
  input  logic                  io_s_r_last,
  input  logic [DATA_W-1:0]     io_s_r_rdata,
  output logic                  io_s_r_ready,
  output logic                  io_s_aw_valid,
  output logic [ADDR_W-1:0]     io_s_aw_addr,
  output logic [7:0]            io_s_aw_len,
  output logic [2:0]            io_s_aw_size,
  output logic [1:0]            io_s_aw_burst,
  input  logic                  io_s_aw_ready,
  output logic                  io_s_w_valid,
  output logic [DATA_W-1:0]     io_s_w_data,
  output logic [DATA_W/8-1:0]   io_s_w_strb,
  output logic                  io_s_w_last,
  input  logic                  io_s_w_ready,
  input  logic                  io_s_b_valid,
  output logic                  io_s_b_ready,
  output logic                  io_busy
);

  typedef enum logic [1:0] {IDLE, RD0, RD1, WR} state_t;

  state_t      state;
  state_t      grant;
  logic        ar_done;
  logic        aw_done;
  logic        busy_q;
  logic [7:0]  beat_cnt;
  logic        own0;
  logic        own1;
  logic        own_rd;
  logic        own_wr;
  logic        beat_hs;
`ifdef ARB_RR_EN
  logic        last_owner;  // 0 = m0, 1 = m1
`endif
`ifdef ARB_CHECK_EN
  logic [7:0]  burst_len;
  logic        beat_last;
`endif

  // Winner selection from the requests sampled in IDLE.
  always_comb begin
    grant = IDLE;
`ifdef ARB_RR_EN
    if (io_m0_ar_valid && (io_m1_aw_valid || io_m1_ar_valid))
      grant = last_owner ? RD0 : (io_m1_aw_valid ? WR : RD1);
    else if (io_m1_aw_valid)
      grant = WR;
    else if (io_m1_ar_valid)
      grant = RD1;
    else if (io_m0_ar_valid)
      grant = RD0;
`else
    if (io_m1_aw_valid)
      grant = WR;
    else if (io_m1_ar_valid)
      grant = RD1;
    else if (io_m0_ar_valid)
      grant = RD0;
`endif
  end

  always_comb begin
    own0   = (state == RD0);
    own1   = (state == RD1);
    own_rd = own0 | own1;
    own_wr = (state == WR);

    io_s_ar_addr  = own0 ? io_m0_ar_addr  : io_m1_ar_addr;
    io_s_ar_len   = own0 ? io_m0_ar_len   : io_m1_ar_len;
    io_s_ar_size  = own0 ? io_m0_ar_size  : io_m1_ar_size;
    io_s_ar_burst = own0 ? io_m0_ar_burst : io_m1_ar_burst;
    io_s_ar_valid = ((own0 & io_m0_ar_valid) | (own1 & io_m1_ar_valid)) & ~ar_done;
    io_m0_ar_ready = own0 & io_s_ar_ready & ~ar_done;
    io_m1_ar_ready = own1 & io_s_ar_ready & ~ar_done;

    io_m0_r_valid = own0 & io_s_r_valid;
    io_m0_r_last  = own0 & io_s_r_last;
    io_m0_r_rdata = io_s_r_rdata;
    io_m1_r_valid = own1 & io_s_r_valid;
    io_m1_r_last  = own1 & io_s_r_last;
    io_m1_r_rdata = io_s_r_rdata;
    io_s_r_ready  = (own0 & io_m0_r_ready) | (own1 & io_m1_r_ready);

    io_s_aw_addr   = io_m1_aw_addr;
    io_s_aw_len    = io_m1_aw_len;
    io_s_aw_size   = io_m1_aw_size;
    io_s_aw_burst  = io_m1_aw_burst;
    io_s_aw_valid  = own_wr & io_m1_aw_valid & ~aw_done;
    io_m1_aw_ready = own_wr & io_s_aw_ready & ~aw_done;

    io_s_w_valid  = own_wr & io_m1_w_valid;
    io_s_w_data   = io_m1_w_data;
    io_s_w_strb   = io_m1_w_strb;
    io_s_w_last   = io_m1_w_last;
    io_m1_w_ready = own_wr & io_s_w_ready;

    io_m1_b_valid = own_wr & io_s_b_valid;
    io_s_b_ready  = own_wr & io_m1_b_ready;

    beat_hs = own_rd ? (io_s_r_valid & io_s_r_ready) : (io_s_w_valid & io_s_w_ready);
`ifdef ARB_CHECK_EN
    beat_last = own_rd ? io_s_r_last : io_m1_w_last;
`endif

    io_busy = busy_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      ar_done  <= 1'b0;
      aw_done  <= 1'b0;
      busy_q   <= 1'b0;
      beat_cnt <= '0;
`ifdef ARB_RR_EN
      last_owner <= 1'b1;
`endif
`ifdef ARB_CHECK_EN
      burst_len <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          ar_done  <= 1'b0;
          aw_done  <= 1'b0;
          beat_cnt <= '0;
          if (grant != IDLE) begin
            state  <= grant;
            busy_q <= 1'b1;
`ifdef ARB_RR_EN
            last_owner <= (grant != RD0);
`endif
`ifdef ARB_CHECK_EN
            burst_len <= (grant == WR)  ? io_m1_aw_len :
                         (grant == RD1) ? io_m1_ar_len : io_m0_ar_len;
`endif
          end
        end
        RD0, RD1: begin
          if (io_s_ar_valid && io_s_ar_ready)
            ar_done <= 1'b1;
          if (beat_hs) begin
            beat_cnt <= beat_cnt + 8'd1;
            if (io_s_r_last) begin
              state    <= IDLE;
              busy_q   <= 1'b0;
              ar_done  <= 1'b0;
              beat_cnt <= '0;
            end
          end
        end
        WR: begin
          if (io_s_aw_valid && io_s_aw_ready)
            aw_done <= 1'b1;
          if (beat_hs)
            beat_cnt <= beat_cnt + 8'd1;
          // Completion is the B handshake, not the last W beat.
          if (io_s_b_valid && io_s_b_ready) begin
            state    <= IDLE;
            busy_q   <= 1'b0;
            aw_done  <= 1'b0;
            beat_cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ARB_CHECK_EN
  // Beat number len+1 must carry last, and no earlier beat may.
  always_ff @(posedge clock) begin
    if (!reset && beat_hs && (beat_last != (beat_cnt == burst_len)))
      $error("axi_arb: burst beat/last fault, beat %0d len %0d last %0b",
             beat_cnt, burst_len, beat_last);
  end
`endif

endmodule

// File: tb/tb_ysyx_22050550_axi_arb.sv
// Directed self-checking bench for ysyx_22050550_axi_arb (default build or ARB_RR_EN).
`timescale 1ns/1ps
module tb_ysyx_22050550_axi_arb;
  logic        clock, reset;
  logic        m0_ar_valid, m0_ar_ready, m0_r_valid, m0_r_last, m0_r_ready;
  logic [63:0] m0_ar_addr, m0_r_rdata;
  logic [7:0]  m0_ar_len;
  logic [2:0]  m0_ar_size;
  logic [1:0]  m0_ar_burst;
  logic        m1_ar_valid, m1_ar_ready, m1_r_valid, m1_r_last, m1_r_ready;
  logic [63:0] m1_ar_addr, m1_r_rdata;
  logic [7:0]  m1_ar_len;
  logic [2:0]  m1_ar_size;
  logic [1:0]  m1_ar_burst;
  logic        m1_aw_valid, m1_aw_ready, m1_w_valid, m1_w_last, m1_w_ready, m1_b_ready, m1_b_valid;
  logic [63:0] m1_aw_addr, m1_w_data;
  logic [7:0]  m1_aw_len, m1_w_strb;
  logic [2:0]  m1_aw_size;
  logic [1:0]  m1_aw_burst;
  logic        s_ar_valid, s_ar_ready, s_r_valid, s_r_last, s_r_ready;
  logic [63:0] s_ar_addr, s_r_rdata;
  logic [7:0]  s_ar_len;
  logic [2:0]  s_ar_size;
  logic [1:0]  s_ar_burst;
  logic        s_aw_valid, s_aw_ready, s_w_valid, s_w_last, s_w_ready, s_b_valid, s_b_ready;
  logic [63:0] s_aw_addr, s_w_data;
  logic [7:0]  s_aw_len, s_w_strb;
  logic [2:0]  s_aw_size;
  logic [1:0]  s_aw_burst;
  logic        busy;

  int total = 0;
  int bad = 0;

  ysyx_22050550_axi_arb #(.ADDR_W(64), .DATA_W(64)) dut (
    .clock(clock), .reset(reset),
    .io_m0_ar_valid(m0_ar_valid), .io_m0_ar_addr(m0_ar_addr), .io_m0_ar_len(m0_ar_len),
    .io_m0_ar_size(m0_ar_size), .io_m0_ar_burst(m0_ar_burst), .io_m0_ar_ready(m0_ar_ready),
    .io_m0_r_valid(m0_r_valid), .io_m0_r_last(m0_r_last), .io_m0_r_rdata(m0_r_rdata),
    .io_m0_r_ready(m0_r_ready),
    .io_m1_ar_valid(m1_ar_valid), .io_m1_ar_addr(m1_ar_addr), .io_m1_ar_len(m1_ar_len),
    .io_m1_ar_size(m1_ar_size), .io_m1_ar_burst(m1_ar_burst), .io_m1_ar_ready(m1_ar_ready),
    .io_m1_r_valid(m1_r_valid), .io_m1_r_last(m1_r_last), .io_m1_r_rdata(m1_r_rdata),
    .io_m1_r_ready(m1_r_ready),
    .io_m1_aw_valid(m1_aw_valid), .io_m1_aw_addr(m1_aw_addr), .io_m1_aw_len(m1_aw_len),
    .io_m1_aw_size(m1_aw_size), .io_m1_aw_burst(m1_aw_burst), .io_m1_aw_ready(m1_aw_ready),
    .io_m1_w_valid(m1_w_valid), .io_m1_w_data(m1_w_data), .io_m1_w_strb(m1_w_strb),
    .io_m1_w_last(m1_w_last), .io_m1_w_ready(m1_w_ready),
    .io_m1_b_ready(m1_b_ready), .io_m1_b_valid(m1_b_valid),
    .io_s_ar_valid(s_ar_valid), .io_s_ar_addr(s_ar_addr), .io_s_ar_len(s_ar_len),
    .io_s_ar_size(s_ar_size), .io_s_ar_burst(s_ar_burst), .io_s_ar_ready(s_ar_ready),
    .io_s_r_valid(s_r_valid), .io_s_r_last(s_r_last), .io_s_r_rdata(s_r_rdata),
    .io_s_r_ready(s_r_ready),
    .io_s_aw_valid(s_aw_valid), .io_s_aw_addr(s_aw_addr), .io_s_aw_len(s_aw_len),
    .io_s_aw_size(s_aw_size), .io_s_aw_burst(s_aw_burst), .io_s_aw_ready(s_aw_ready),
    .io_s_w_valid(s_w_valid), .io_s_w_data(s_w_data), .io_s_w_strb(s_w_strb),
    .io_s_w_last(s_w_last), .io_s_w_ready(s_w_ready),
    .io_s_b_valid(s_b_valid), .io_s_b_ready(s_b_ready),
    .io_busy(busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Inputs change 1ns after the rising edge; outputs are sampled 2ns later.
  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs;
    m0_ar_valid = 0; m0_ar_addr = '0; m0_ar_len = '0; m0_ar_size = '0; m0_ar_burst = '0; m0_r_ready = 0;
    m1_ar_valid = 0; m1_ar_addr = '0; m1_ar_len = '0; m1_ar_size = '0; m1_ar_burst = '0; m1_r_ready = 0;
    m1_aw_valid = 0; m1_aw_addr = '0; m1_aw_len = '0; m1_aw_size = '0; m1_aw_burst = '0;
    m1_w_valid = 0; m1_w_data = '0; m1_w_strb = '0; m1_w_last = 0; m1_b_ready = 0;
    s_ar_ready = 0; s_r_valid = 0; s_r_last = 0; s_r_rdata = '0;
    s_aw_ready = 0; s_w_ready = 0; s_b_valid = 0;
  endtask

  task automatic test_reset;
    logic [10:0] v;
    reset = 1; idle_inputs();
    step(); step();
    #2;
    v = {s_ar_valid, s_aw_valid, s_w_valid, busy, m0_ar_ready, m1_ar_ready,
         m1_aw_ready, m1_w_ready, m0_r_valid, m1_r_valid, m1_b_valid};
    total++; if (v !== 11'h0) begin bad++; $display("FAIL reset_in_reset got=%b exp=0", v); end
    total++; if (dut.beat_cnt !== 8'd0) begin bad++; $display("FAIL reset_beat_cnt got=%0d exp=0", dut.beat_cnt); end
    step();
    reset = 0;
    // Slave readies/valids high with no request: nothing may leak through.
    s_ar_ready = 1; s_aw_ready = 1; s_w_ready = 1; s_r_valid = 1; s_b_valid = 1;
    for (int i = 0; i < 3; i++) begin
      #2;
      v = {s_ar_valid, s_aw_valid, s_w_valid, busy, m0_ar_ready, m1_ar_ready,
           m1_aw_ready, m1_w_ready, m0_r_valid, m1_r_valid, m1_b_valid};
      total++; if (v !== 11'h0) begin bad++; $display("FAIL reset_hold%0d got=%b exp=0", i, v); end
      step();
    end
    idle_inputs();
  endtask

  task automatic test_read_m0;
    step();
    m0_ar_valid = 1; m0_ar_addr = 64'h8000_0000; m0_ar_len = 8'd1; m0_ar_size = 3'd3; m0_ar_burst = 2'd1;
    s_ar_ready = 1; m0_r_ready = 1;
    #2;
    total++; if ({busy, s_ar_valid} !== 2'b00) begin bad++; $display("FAIL rd0_idle got=%b exp=00", {busy, s_ar_valid}); end
    step(); #2;
    total++; if ({busy, s_ar_valid, m0_ar_ready, m1_ar_ready} !== 4'b1110) begin bad++; $display("FAIL rd0_grant got=%b exp=1110", {busy, s_ar_valid, m0_ar_ready, m1_ar_ready}); end
    total++; if (s_ar_addr !== 64'h8000_0000) begin bad++; $display("FAIL rd0_addr got=%h exp=80000000", s_ar_addr); end
    total++; if (s_ar_len !== 8'd1) begin bad++; $display("FAIL rd0_len got=%0d exp=1", s_ar_len); end
    step();
    m0_ar_valid = 0; s_r_valid = 1; s_r_rdata = 64'h11; s_r_last = 0;
    #2;
    total++; if ({s_ar_valid, m0_r_valid, m1_r_valid, s_r_ready} !== 4'b0101) begin bad++; $display("FAIL rd0_beat0_ctl got=%b exp=0101", {s_ar_valid, m0_r_valid, m1_r_valid, s_r_ready}); end
    total++; if (m0_r_rdata !== 64'h11) begin bad++; $display("FAIL rd0_beat0_data got=%h exp=11", m0_r_rdata); end
    step();
    s_r_rdata = 64'h22; s_r_last = 1;
    #2;
    total++; if ({m0_r_valid, m0_r_last, m1_r_valid} !== 3'b110) begin bad++; $display("FAIL rd0_beat1_ctl got=%b exp=110", {m0_r_valid, m0_r_last, m1_r_valid}); end
    total++; if (m0_r_rdata !== 64'h22) begin bad++; $display("FAIL rd0_beat1_data got=%h exp=22", m0_r_rdata); end
    step();
    s_r_valid = 0; s_r_last = 0;
    #2;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rd0_done_idle got=%b exp=0", busy); end
    idle_inputs();
  endtask

  task automatic test_wr_priority;
    step();
    m1_aw_valid = 1; m1_aw_addr = 64'h8000_0040; m1_aw_len = 8'd1; m1_aw_size = 3'd3; m1_aw_burst = 2'd1;
    m0_ar_valid = 1; m0_ar_addr = 64'h8000_0100; m0_ar_len = 8'd1;
    s_aw_ready = 1; s_w_ready = 1; s_ar_ready = 1; m1_b_ready = 1; m0_r_ready = 1;
    #2;
    total++; if ({busy, m0_ar_ready, m1_aw_ready} !== 3'b000) begin bad++; $display("FAIL wr_idle got=%b exp=000", {busy, m0_ar_ready, m1_aw_ready}); end
    step(); #2;
    total++; if ({s_aw_valid, m1_aw_ready, m0_ar_ready, s_ar_valid} !== 4'b1100) begin bad++; $display("FAIL wr_grant got=%b exp=1100", {s_aw_valid, m1_aw_ready, m0_ar_ready, s_ar_valid}); end
    total++; if (s_aw_addr !== 64'h8000_0040) begin bad++; $display("FAIL wr_addr got=%h exp=80000040", s_aw_addr); end
    step();
    m1_aw_valid = 0; m1_w_valid = 1; m1_w_data = 64'hAA; m1_w_strb = 8'hFF; m1_w_last = 0;
    #2;
    total++; if ({s_aw_valid, s_w_valid, m1_w_ready, m0_ar_ready} !== 4'b0110) begin bad++; $display("FAIL wr_beat0 got=%b exp=0110", {s_aw_valid, s_w_valid, m1_w_ready, m0_ar_ready}); end
    total++; if (s_w_data !== 64'hAA) begin bad++; $display("FAIL wr_data0 got=%h exp=aa", s_w_data); end
    step();
    m1_w_data = 64'hBB; m1_w_last = 1;
    #2;
    total++; if ({s_w_valid, s_w_last, m1_b_valid, busy} !== 4'b1101) begin bad++; $display("FAIL wr_beat1 got=%b exp=1101", {s_w_valid, s_w_last, m1_b_valid, busy}); end
    step();
    m1_w_valid = 0; m1_w_last = 0; s_b_valid = 1;
    #2;
    total++; if ({m1_b_valid, s_b_ready, busy} !== 3'b111) begin bad++; $display("FAIL wr_resp got=%b exp=111", {m1_b_valid, s_b_ready, busy}); end
    step();
    s_b_valid = 0;
    #2;
    total++; if ({busy, s_ar_valid, m0_ar_ready} !== 3'b000) begin bad++; $display("FAIL wr_turnaround got=%b exp=000", {busy, s_ar_valid, m0_ar_ready}); end
    step(); #2;
    total++; if ({busy, s_ar_valid, m0_ar_ready} !== 3'b111) begin bad++; $display("FAIL wr_then_rd0 got=%b exp=111", {busy, s_ar_valid, m0_ar_ready}); end
    total++; if (s_ar_addr !== 64'h8000_0100) begin bad++; $display("FAIL wr_then_rd0_addr got=%h exp=80000100", s_ar_addr); end
    step();
    m0_ar_valid = 0; s_r_valid = 1; s_r_rdata = 64'h33; s_r_last = 0;
    step();
    s_r_last = 1;
    step();
    s_r_valid = 0; s_r_last = 0;
    #2;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL wr_rd0_done got=%b exp=0", busy); end
    idle_inputs();
  endtask

  task automatic test_priority;
    logic [2:0] exp_m1;
`ifdef ARB_RR_EN
    exp_m1 = 3'b010;  // RD0, RD1, RD0 starting from last_owner = m1
`else
    exp_m1 = 3'b111;  // RD1 every time, m0 starves
`endif
    step();
    reset = 1;
    step();
    reset = 0;
    m0_ar_valid = 1; m0_ar_addr = 64'h8000_0200; m0_ar_len = 8'd1;
    m1_ar_valid = 1; m1_ar_addr = 64'h8000_0300; m1_ar_len = 8'd1;
    s_ar_ready = 1; m0_r_ready = 1; m1_r_ready = 1;
    for (int g = 0; g < 3; g++) begin
      #2;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL prio_idle%0d got=%b exp=0", g, busy); end
      step(); #2;
      total++; if ({busy, m0_ar_ready, m1_ar_ready} !== {1'b1, ~exp_m1[g], exp_m1[g]}) begin
        bad++; $display("FAIL prio_grant%0d got=%b exp=%b", g, {busy, m0_ar_ready, m1_ar_ready}, {1'b1, ~exp_m1[g], exp_m1[g]}); end
      total++; if (s_ar_addr !== (exp_m1[g] ? 64'h8000_0300 : 64'h8000_0200)) begin
        bad++; $display("FAIL prio_addr%0d got=%h exp=%h", g, s_ar_addr, exp_m1[g] ? 64'h8000_0300 : 64'h8000_0200); end
      step();
      s_r_valid = 1; s_r_last = 0;
      #2;
      total++; if ({s_ar_valid, m0_r_valid, m1_r_valid} !== {1'b0, ~exp_m1[g], exp_m1[g]}) begin
        bad++; $display("FAIL prio_route%0d got=%b exp=%b", g, {s_ar_valid, m0_r_valid, m1_r_valid}, {1'b0, ~exp_m1[g], exp_m1[g]}); end
      step();
      s_r_last = 1;
      step();
      s_r_valid = 0; s_r_last = 0;
    end
    idle_inputs();
  endtask

  task automatic test_ar_stall;
    step();
    m1_ar_valid = 1; m1_ar_addr = 64'h8000_0080; m1_ar_len = 8'd1; s_ar_ready = 0; m1_r_ready = 1;
    step();
    for (int i = 0; i < 4; i++) begin
      #2;
      total++; if ({s_ar_valid, m1_ar_ready} !== 2'b10) begin bad++; $display("FAIL stall_valid%0d got=%b exp=10", i, {s_ar_valid, m1_ar_ready}); end
      total++; if (s_ar_addr !== 64'h8000_0080) begin bad++; $display("FAIL stall_addr%0d got=%h exp=80000080", i, s_ar_addr); end
      step();
    end
    s_ar_ready = 1;
    #2;
    total++; if ({s_ar_valid, m1_ar_ready} !== 2'b11) begin bad++; $display("FAIL stall_hs got=%b exp=11", {s_ar_valid, m1_ar_ready}); end
    for (int i = 0; i < 2; i++) begin
      step(); #2;
      total++; if ({s_ar_valid, m1_ar_ready, busy} !== 3'b001) begin bad++; $display("FAIL stall_no_reissue%0d got=%b exp=001", i, {s_ar_valid, m1_ar_ready, busy}); end
    end
    step();
    m1_ar_valid = 0; s_r_valid = 1; s_r_last = 0;
    step();
    s_r_last = 1;
    #2;
    total++; if ({m1_r_valid, m1_r_last, m0_r_valid} !== 3'b110) begin bad++; $display("FAIL stall_last got=%b exp=110", {m1_r_valid, m1_r_last, m0_r_valid}); end
    step();
    s_r_valid = 0; s_r_last = 0;
    #2;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL stall_done got=%b exp=0", busy); end
    idle_inputs();
  endtask

  task automatic test_reset_mid;
    logic [5:0] v;
    step();
    m0_ar_valid = 1; m0_ar_addr = 64'h8000_0000; m0_ar_len = 8'd1; s_ar_ready = 1; m0_r_ready = 1;
    step();
    step();
    m0_ar_valid = 0; s_r_valid = 1; s_r_rdata = 64'h44; s_r_last = 0;
    step();
    reset = 1; s_r_rdata = 64'h55;
    #2;
    total++; if (dut.beat_cnt !== 8'd1) begin bad++; $display("FAIL mid_beat_cnt_before got=%0d exp=1", dut.beat_cnt); end
    step();
    reset = 0;
    #2;
    v = {busy, s_ar_valid, m0_r_valid, m1_r_valid, s_aw_valid, s_w_valid};
    total++; if (v !== 6'h0) begin bad++; $display("FAIL mid_reset_idle got=%b exp=0", v); end
    total++; if (dut.beat_cnt !== 8'd0) begin bad++; $display("FAIL mid_reset_beat_cnt got=%0d exp=0", dut.beat_cnt); end
    idle_inputs();
    step();
  endtask

  initial begin
    test_reset();
    test_read_m0();
    test_wr_priority();
    test_priority();
    test_ar_stall();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ysyx_22050550_axi_arb.md
# ysyx_22050550_axi_arb

Two-master, one-slave AXI4 arbiter that shares the single memory-side AXI port between the instruction cache (master 0, read-only) and the data cache (master 1, read and write-back). It sits between the two `ysyx_22050550_CACHE` instances and the AXI SRAM/crossbar.
- Exactly one burst transaction is outstanding on the slave port at any time, read or write.
- The arbiter keeps ownership until the transaction completes, so the caches' 2-beat refill and replace bursts are never interleaved.

## Interface
Parameters:
- ADDR_W, 64, AXI address width.
- DATA_W, 64, AXI data width; strobe width is DATA_W/8.

Ports (bundles list fields; widths as in the caches: addr ADDR_W, len 8, size 3, burst 2, data DATA_W, strb DATA_W/8, others 1):
- clock  in  1  clock.
- reset  in  1  synchronous, active-high.
- io_m0_ar_{valid,addr,len,size,burst}  in; io_m0_ar_ready  out  — I-cache read address.
- io_m0_r_{valid,last,rdata}  out; io_m0_r_ready  in  — I-cache read data.
- io_m1_ar_{valid,addr,len,size,burst}  in; io_m1_ar_ready  out  — D-cache read address.
- io_m1_r_{valid,last,rdata}  out; io_m1_r_ready  in  — D-cache read data.
- io_m1_aw_{valid,addr,len,size,burst}  in; io_m1_aw_ready  out  — D-cache write-back address.
- io_m1_w_{valid,data,strb,last}  in; io_m1_w_ready  out  — D-cache write-back data.
- io_m1_b_ready  in; io_m1_b_valid  out  — D-cache write response.
- io_s_ar_*, io_s_aw_*, io_s_w_*, io_s_r_ready, io_s_b_ready  out; io_s_ar_ready, io_s_aw_ready, io_s_w_ready, io_s_r_{valid,last,rdata}, io_s_b_valid  in  — slave side, same field sets.
- io_busy  out  1  high whenever state ≠ IDLE.

## Operation
States: IDLE, RD0 (m0 owns read), RD1 (m1 owns read), WR (m1 owns write).

IDLE
- Requests sampled: wreq = m1_aw_valid, rreq1 = m1_ar_valid, rreq0 = m0_ar_valid.
- Winner is registered; the state moves to RD0/RD1/WR on the next edge.
- No request: stay in IDLE.

RDx
- Owner's AR fields are forwarded to io_s_ar_*. io_s_ar_valid = owner ar_valid & !ar_done.
- ar_done is set on the s_ar handshake and cleared on leaving the state.
- s_ar_ready is returned only to the owner.
- io_s_r_* go to the owner only; the other master's r_valid is 0. io_s_r_ready = owner r_ready.
- Exit to IDLE on s_r_valid & s_r_ready & s_r_last.

WR
- m1 AW/W forwarded. aw_valid is gated by aw_done, set on the aw handshake.
- W is forwarded unconditionally.
- io_m1_b_valid = io_s_b_valid; io_s_b_ready = io_m1_b_ready.
- Exit to IDLE on s_b_valid & s_b_ready.

Outside ownership
- All slave-side valids and master-side readies/valids are 0.
- Address, data and attribute buses pass through the owner mux and are don't-care.

Beat counter
- An 8-bit counter counts r or w beats in the current burst; it resets in IDLE.
- A last flag before len+1 beats, or beat len+1 without last, is a protocol fault. It is reported only when ARB_CHECK_EN is defined (see Configuration).

Priority
- Fixed: WR > RD1 > RD0. With ARB_RR_EN, see Configuration.

## Timing
- Reset values: state IDLE, ar_done = aw_done = 0, beat counter 0, last_owner = m1, io_busy 0.
- All master-side readies and valids are 0 at reset; all slave-side valids are 0 at reset.
- Grant latency: a request seen in IDLE at cycle N appears on the slave port at cycle N+1 (combinational forward in the new state).
- Turnaround: at least one IDLE cycle between consecutive transactions.
- Request withdrawn before the grant edge: the decision uses the values sampled in the IDLE cycle. A master that drops valid after being granted leaves the arbiter in RDx/WR until completion. Caches must not do this.
- Simultaneous completion and new request: the completion edge always goes to IDLE. The new request is granted one cycle later.
- Reset mid-burst: immediate return to IDLE with all valids low. Slave and caches are reset in the same cycle.
- A write-back followed by a refill from m1 (miss→replace→miss→refill) is two separate grants; with ARB_RR_EN, a pending m0 read may be inserted between them.

## Configuration
- ARB_RR_EN defined: round-robin between masters.
  - last_owner is updated at each grant.
  - When both masters request in IDLE, the master not equal to last_owner wins.
  - Within m1, write beats read.
- ARB_RR_EN undefined: fixed priority WR > RD1 > RD0; last_owner is unused.
- ARB_CHECK_EN defined: on a beat-counter protocol fault, raise a simulation $error.
- ARB_CHECK_EN undefined: the fault check is compiled out.

## Test plan
- After reset, hold for 3 cycles: all slave valids 0, io_busy 0, m0/m1 readies 0.
- m0 ar_valid, addr 0x8000_0000, len 1; slave returns 2 beats 0x11, 0x22 with last on the second: m0 receives both beats, m1_r_valid stays 0, and the state is IDLE 1 cycle after last.
- m1 aw (addr 0x8000_0040, len 1) and m0 ar asserted in the same cycle: WR is granted first and m0_ar_ready stays 0. After b handshake plus 1 IDLE cycle, RD0 is granted.
- ARB_RR_EN, m0 and m1 issue continuous reads: grants alternate RD0, RD1, RD0. Undefined: RD1 is repeatedly granted while m0 waits.
- Slave stalls s_ar_ready for 4 cycles in RD1: s_ar_valid is held with a stable address, then a single handshake; ar_valid is not re-issued after ar_done.
- Reset asserted during beat 1 of a read burst: the next cycle is IDLE, all valids are 0, and the beat counter is 0.
